// File: rtl/can_rx_frame_pkg.sv
// Shared constants, state/error enums and the CRC-15 step function for the
// CAN 2.0A receive path (also usable by the transmit side).
package can_rx_frame_pkg;

    localparam int ID_SIZE        = 11;
    localparam int DATA_SIZE      = 64;
    localparam int CRC_SIZE       = 15;
    localparam int BUS_IDLE_COUNT = 11;
    localparam int EOF_SIZE       = 7;

    localparam logic REC = 1'b1;
    localparam logic DOM = 1'b0;

    localparam logic [CRC_SIZE-1:0] CRC_POLY = 15'h4599;

    typedef enum logic [3:0] {
        WAIT_IDLE = 4'd0,
        IDLE      = 4'd1,
        ARB       = 4'd2,
        CTRL      = 4'd3,
        DATA      = 4'd4,
        CRC       = 4'd5,
        CRC_DELIM = 4'd6,
        ACK       = 4'd7,
        ACK_DELIM = 4'd8,
        EOF       = 4'd9,
        ERROR     = 4'd10
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_STUFF = 2'd0,
        ERR_CRC   = 2'd1,
        ERR_FORM  = 2'd2
    } rx_err_t;

    // One serial step of the CAN CRC-15: feedback is the MSB xor the incoming bit.
    function automatic logic [CRC_SIZE-1:0] crc15_step(input logic [CRC_SIZE-1:0] crc_in,
                                                        input logic bit_in);
        logic [CRC_SIZE-1:0] shifted;
        shifted = {crc_in[CRC_SIZE-2:0], 1'b0};
        if ((crc_in[CRC_SIZE-1] ^ bit_in) == 1'b1) begin
            return shifted ^ CRC_POLY;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/can_rx_frame_if.sv
// Bus-side and host-side signals of the CAN frame receiver.
interface can_rx_frame_if;
    import can_rx_frame_pkg::*;

    logic                 rx_bit;
    logic [ID_SIZE-1:0]   Rx_ID;
    logic                 ack_drive;
    logic [DATA_SIZE-1:0] Rx_packet;
    logic [3:0]           Rx_dlc;
    logic                 data_out_req;
    logic                 remote_req;
    logic                 rx_error;
    logic [1:0]           rx_err_code;
    logic [7:0]           Rx_Ecount;

    modport master (
        output rx_bit, Rx_ID,
        input  ack_drive, Rx_packet, Rx_dlc, data_out_req, remote_req,
               rx_error, rx_err_code, Rx_Ecount
    );

    modport slave (
        input  rx_bit, Rx_ID,
        output ack_drive, Rx_packet, Rx_dlc, data_out_req, remote_req,
               rx_error, rx_err_code, Rx_Ecount
    );
endinterface

// File: rtl/can_rx_frame_crc15.sv
// Serial CAN CRC-15 register; clear wins over shift.
module can_crc15
    import can_rx_frame_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                shift_en,
    input  logic                bit_in,
    output logic [CRC_SIZE-1:0] crc
);

    // CRC accumulator
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (shift_en) begin
            crc <= crc15_step(crc, bit_in);
        end else begin
            crc <= crc;
        end
    end

endmodule

// File: rtl/can_rx_frame.sv
// CAN 2.0A frame receiver: destuffing, field parsing, CRC-15 check, ACK drive,
// error detection and delivery of frames matching the acceptance ID.
module can_rx_frame
    import can_rx_frame_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    can_rx_frame_if.slave bus
);

    rx_state_t            state_r, state_s;
    logic [3:0]           idle_cnt_r, idle_cnt_s;
    logic [6:0]           bit_cnt_r, bit_cnt_s;
    logic [2:0]           stuff_cnt_r, stuff_cnt_s;
    logic                 last_bit_r, last_bit_s;
    logic [ID_SIZE-1:0]   id_r, id_s;
    logic                 rtr_r, rtr_s;
    logic [3:0]           dlc_r, dlc_s;
    logic [DATA_SIZE-1:0] data_r, data_s;
    logic [CRC_SIZE-1:0]  crc_rx_r, crc_rx_s;
    logic                 crc_ok_r, crc_ok_s;

    logic                 ack_r, ack_s;
    logic [DATA_SIZE-1:0] packet_r, packet_s;
    logic [3:0]           rx_dlc_r, rx_dlc_s;
    logic                 data_req_r, data_req_s;
    logic                 remote_r, remote_s;
    logic                 err_r, err_s;
    logic [1:0]           err_code_r, err_code_s;
    logic [7:0]           ecount_r, ecount_s;

    logic                 rx_s;
    logic                 destuff_s, stuff_slot_s, take_s;
    logic                 raise_s;
    rx_err_t              err_kind_s;
    logic                 crc_clear_s, crc_shift_s;
    logic [CRC_SIZE-1:0]  crc_calc_s;
    logic [3:0]           dlc_full_s;
    logic [5:0]           data_idx_s;

    assign rx_s = bus.rx_bit;

    can_crc15 u_crc (
        .clock    (clock),
        .reset    (reset),
        .clear    (crc_clear_s),
        .shift_en (crc_shift_s),
        .bit_in   (rx_s),
        .crc      (crc_calc_s)
    );

    // Next-state, destuffing, field capture and output decisions
    always_comb begin
        state_s      = state_r;
        idle_cnt_s   = idle_cnt_r;
        bit_cnt_s    = bit_cnt_r;
        stuff_cnt_s  = stuff_cnt_r;
        last_bit_s   = last_bit_r;
        id_s         = id_r;
        rtr_s        = rtr_r;
        dlc_s        = dlc_r;
        data_s       = data_r;
        crc_rx_s     = crc_rx_r;
        crc_ok_s     = crc_ok_r;
        ack_s        = 1'b0;
        packet_s     = packet_r;
        rx_dlc_s     = rx_dlc_r;
        data_req_s   = 1'b0;
        remote_s     = 1'b0;
        err_s        = 1'b0;
        err_code_s   = err_code_r;
        ecount_s     = ecount_r;
        raise_s      = 1'b0;
        err_kind_s   = ERR_FORM;
        crc_clear_s  = 1'b0;
        crc_shift_s  = 1'b0;
        dlc_full_s   = {dlc_r[2:0], rx_s};
        data_idx_s   = 6'(DATA_SIZE - 1) - bit_cnt_r[5:0];

        destuff_s    = (state_r == ARB) || (state_r == CTRL) ||
                       (state_r == DATA) || (state_r == CRC);
        stuff_slot_s = destuff_s && (stuff_cnt_r == 3'd5);
        take_s       = destuff_s && !stuff_slot_s;

        // A stuff bit restarts the run with its own value; it is never parsed.
        if (stuff_slot_s) begin
            if (rx_s == last_bit_r) begin
                raise_s    = 1'b1;
                err_kind_s = ERR_STUFF;
            end else begin
                stuff_cnt_s = 3'd1;
                last_bit_s  = rx_s;
            end
        end else if (take_s) begin
            if (rx_s == last_bit_r) begin
                stuff_cnt_s = stuff_cnt_r + 3'd1;
            end else begin
                stuff_cnt_s = 3'd1;
                last_bit_s  = rx_s;
            end
        end else begin
            stuff_cnt_s = stuff_cnt_r;
        end

        case (state_r)
            WAIT_IDLE, ERROR: begin
                if (rx_s == REC) begin
                    if (idle_cnt_r == 4'(BUS_IDLE_COUNT - 1)) begin
                        idle_cnt_s = 4'd0;
                        state_s    = IDLE;
                    end else begin
                        idle_cnt_s = idle_cnt_r + 4'd1;
                    end
                end else begin
                    idle_cnt_s = 4'd0;
                end
            end
            IDLE: begin
                if (rx_s == DOM) begin
                    crc_clear_s = 1'b1;
                    stuff_cnt_s = 3'd1;
                    last_bit_s  = DOM;
                    bit_cnt_s   = 7'd0;
                    id_s        = '0;
                    dlc_s       = 4'd0;
                    data_s      = '0;
                    state_s     = ARB;
                end else begin
                    state_s = IDLE;
                end
            end
            ARB: begin
                if (take_s) begin
                    crc_shift_s = 1'b1;
                    if (bit_cnt_r < 7'(ID_SIZE)) begin
                        id_s      = {id_r[ID_SIZE-2:0], rx_s};
                        bit_cnt_s = bit_cnt_r + 7'd1;
                    end else begin
                        rtr_s     = rx_s;
                        bit_cnt_s = 7'd0;
                        state_s   = CTRL;
                    end
                end else begin
                    state_s = ARB;
                end
            end
            CTRL: begin
                if (take_s) begin
                    crc_shift_s = 1'b1;
                    bit_cnt_s   = bit_cnt_r + 7'd1;
                    if (bit_cnt_r == 7'd0) begin
                        if (rx_s == REC) begin
                            raise_s    = 1'b1;
                            err_kind_s = ERR_FORM;
                        end else begin
                            raise_s = 1'b0;
                        end
                    end else if (bit_cnt_r == 7'd5) begin
                        dlc_s     = (dlc_full_s > 4'd8) ? 4'd8 : dlc_full_s;
                        bit_cnt_s = 7'd0;
                        if (rtr_r || (dlc_full_s == 4'd0)) begin
                            state_s = CRC;
                        end else begin
                            state_s = DATA;
                        end
                    end else if (bit_cnt_r >= 7'd2) begin
                        dlc_s = dlc_full_s;
                    end else begin
                        dlc_s = dlc_r;
                    end
                end else begin
                    state_s = CTRL;
                end
            end
            DATA: begin
                if (take_s) begin
                    crc_shift_s        = 1'b1;
                    data_s[data_idx_s] = rx_s;
                    if (bit_cnt_r == ({dlc_r, 3'b000} - 7'd1)) begin
                        bit_cnt_s = 7'd0;
                        state_s   = CRC;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 7'd1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            CRC: begin
                if (take_s) begin
                    crc_rx_s = {crc_rx_r[CRC_SIZE-2:0], rx_s};
                    if (bit_cnt_r == 7'(CRC_SIZE - 1)) begin
                        bit_cnt_s = 7'd0;
                        state_s   = CRC_DELIM;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 7'd1;
                    end
                end else begin
                    state_s = CRC;
                end
            end
            CRC_DELIM: begin
                if (rx_s == DOM) begin
                    raise_s    = 1'b1;
                    err_kind_s = ERR_FORM;
                end else begin
                    crc_ok_s = (crc_rx_r == crc_calc_s);
                    ack_s    = crc_ok_s;
                    state_s  = ACK;
                end
            end
            ACK: begin
                state_s = ACK_DELIM;
            end
            ACK_DELIM: begin
                if (rx_s == DOM) begin
                    raise_s    = 1'b1;
                    err_kind_s = ERR_FORM;
                end else if (!crc_ok_r) begin
                    raise_s    = 1'b1;
                    err_kind_s = ERR_CRC;
                end else begin
                    bit_cnt_s = 7'd0;
                    state_s   = EOF;
                end
            end
            EOF: begin
                if (rx_s == DOM) begin
                    raise_s    = 1'b1;
                    err_kind_s = ERR_FORM;
                end else if (bit_cnt_r == 7'(EOF_SIZE - 1)) begin
                    if (id_r == bus.Rx_ID) begin
                        data_req_s = !rtr_r;
                        remote_s   = rtr_r;
                        if (!rtr_r) begin
                            packet_s = data_r;
                            rx_dlc_s = dlc_r;
                        end else begin
                            packet_s = packet_r;
                        end
                    end else begin
                        data_req_s = 1'b0;
                    end
                    ecount_s  = (ecount_r != 8'd0) ? (ecount_r - 8'd1) : ecount_r;
                    bit_cnt_s = 7'd0;
                    state_s   = IDLE;
                end else begin
                    bit_cnt_s = bit_cnt_r + 7'd1;
                end
            end
            default: begin
                idle_cnt_s = 4'd0;
                state_s    = WAIT_IDLE;
            end
        endcase

        if (raise_s) begin
            err_s      = 1'b1;
            err_code_s = err_kind_s;
            ecount_s   = (ecount_r == 8'hFF) ? ecount_r : (ecount_r + 8'd1);
            ack_s      = 1'b0;
            data_req_s = 1'b0;
            remote_s   = 1'b0;
            idle_cnt_s = 4'd0;
            state_s    = ERROR;
        end else begin
            err_s = 1'b0;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= WAIT_IDLE;
            idle_cnt_r  <= 4'd0;
            bit_cnt_r   <= 7'd0;
            stuff_cnt_r <= 3'd0;
            last_bit_r  <= 1'b0;
            id_r        <= '0;
            rtr_r       <= 1'b0;
            dlc_r       <= 4'd0;
            data_r      <= '0;
            crc_rx_r    <= '0;
            crc_ok_r    <= 1'b0;
            ack_r       <= 1'b0;
            packet_r    <= '0;
            rx_dlc_r    <= 4'd0;
            data_req_r  <= 1'b0;
            remote_r    <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= 2'd0;
            ecount_r    <= 8'd0;
        end else begin
            state_r     <= state_s;
            idle_cnt_r  <= idle_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            stuff_cnt_r <= stuff_cnt_s;
            last_bit_r  <= last_bit_s;
            id_r        <= id_s;
            rtr_r       <= rtr_s;
            dlc_r       <= dlc_s;
            data_r      <= data_s;
            crc_rx_r    <= crc_rx_s;
            crc_ok_r    <= crc_ok_s;
            ack_r       <= ack_s;
            packet_r    <= packet_s;
            rx_dlc_r    <= rx_dlc_s;
            data_req_r  <= data_req_s;
            remote_r    <= remote_s;
            err_r       <= err_s;
            err_code_r  <= err_code_s;
            ecount_r    <= ecount_s;
        end
    end

    assign bus.ack_drive    = ack_r;
    assign bus.Rx_packet    = packet_r;
    assign bus.Rx_dlc       = rx_dlc_r;
    assign bus.data_out_req = data_req_r;
    assign bus.remote_req   = remote_r;
    assign bus.rx_error     = err_r;
    assign bus.rx_err_code  = err_code_r;
    assign bus.Rx_Ecount    = ecount_r;

endmodule

// File: tb/tb_can_rx_frame.sv
// Directed bench for can_rx_frame: builds stuffed CAN frames bit by bit and
// checks ACK, delivery pulses, error codes and the error counter.
module tb_can_rx_frame;
    import can_rx_frame_pkg::*;

    logic clock = 1'b0;
    logic reset;

    can_rx_frame_if bus ();

    can_rx_frame dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    bit frame_q[$];
    int ack_n, ack_at, dout_n, dout_at, rem_n, rem_at, err_n, err_at;

    localparam logic [63:0] PKT_A = 64'hA55A_0000_0000_0000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raw fields, CRC over SOF..data, then stuffing up to the last CRC bit.
    task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                               input logic [63:0] data, input int crc_flip, input int eof_dom);
        bit raw[$];
        logic [14:0] crc;
        logic nxt;
        int nbytes, cnt;
        bit last;
        raw.delete();
        frame_q.delete();
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(1'b0);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nbytes = (dlc > 4'd8) ? 8 : int'(dlc);
        if (!rtr) begin
            for (int i = 0; i < nbytes * 8; i++) raw.push_back(data[63 - i]);
        end
        crc = 15'h0;
        foreach (raw[i]) begin
            nxt = raw[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (nxt) crc = crc ^ 15'h4599;
        end
        if (crc_flip >= 0) crc[crc_flip] = ~crc[crc_flip];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        cnt  = 0;
        last = 1'b1;
        for (int i = 0; i < raw.size(); i++) begin
            frame_q.push_back(raw[i]);
            if (raw[i] == last) cnt++;
            else begin cnt = 1; last = raw[i]; end
            if (cnt == 5 && i < raw.size() - 1) begin
                frame_q.push_back(~last);
                last = ~last;
                cnt  = 1;
            end
        end
        frame_q.push_back(1'b1);
        frame_q.push_back(1'b0);
        frame_q.push_back(1'b1);
        for (int i = 0; i < 7; i++) frame_q.push_back((i == eof_dom) ? 1'b0 : 1'b1);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.rx_bit = 1'b1;
        end
    endtask

    task automatic send_frame(input int nbits);
        ack_n = 0; dout_n = 0; rem_n = 0; err_n = 0;
        ack_at = -1; dout_at = -1; rem_at = -1; err_at = -1;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            bus.rx_bit = frame_q[i];
            @(posedge clock);
            #1;
            if (bus.ack_drive)    begin ack_n++;  if (ack_at  < 0) ack_at  = i; end
            if (bus.data_out_req) begin dout_n++; if (dout_at < 0) dout_at = i; end
            if (bus.remote_req)   begin rem_n++;  if (rem_at  < 0) rem_at  = i; end
            if (bus.rx_error)     begin err_n++;  if (err_at  < 0) err_at  = i; end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"},    64'(bus.ack_drive),    64'd0);
        check({tag, "_pkt"},    bus.Rx_packet,         64'd0);
        check({tag, "_dlc"},    64'(bus.Rx_dlc),       64'd0);
        check({tag, "_pulses"}, 64'({bus.data_out_req, bus.remote_req, bus.rx_error}), 64'd0);
        check({tag, "_code"},   64'(bus.rx_err_code),  64'd0);
        check({tag, "_ecnt"},   64'(bus.Rx_Ecount),    64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        bus.rx_bit = 1'b1;
        bus.Rx_ID  = 11'h123;
        #12;
        check_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // Good data frame, matching ID
        send_idle(11);
        build_frame(11'h123, 1'b0, 4'd2, PKT_A, -1, -1);
        send_frame(frame_q.size());
        check("a_ack_n",   64'(ack_n),   64'd1);
        check("a_ack_at",  64'(ack_at),  64'(frame_q.size() - 10));
        check("a_dout_n",  64'(dout_n),  64'd1);
        check("a_dout_at", 64'(dout_at), 64'(frame_q.size() - 1));
        check("a_err_n",   64'(err_n),   64'd0);
        check("a_pkt",     bus.Rx_packet, PKT_A);
        check("a_dlc",     64'(bus.Rx_dlc), 64'd2);

        // Same frame, non-matching ID: ACKed but not delivered
        send_idle(3);
        bus.Rx_ID = 11'h124;
        send_frame(frame_q.size());
        check("nm_ack_n",  64'(ack_n),  64'd1);
        check("nm_dout_n", 64'(dout_n), 64'd0);
        check("nm_pkt",    bus.Rx_packet, PKT_A);

        // Remote frame with DLC 4: no data field expected
        send_idle(3);
        bus.Rx_ID = 11'h7F0;
        build_frame(11'h7F0, 1'b1, 4'd4, 64'd0, -1, -1);
        send_frame(frame_q.size());
        check("rtr_rem_n",  64'(rem_n),  64'd1);
        check("rtr_rem_at", 64'(rem_at), 64'(frame_q.size() - 1));
        check("rtr_dout_n", 64'(dout_n), 64'd0);
        check("rtr_err_n",  64'(err_n),  64'd0);
        check("rtr_dlc",    64'(bus.Rx_dlc), 64'd2);

        // DLC 15 clamps to 8 bytes
        send_idle(3);
        bus.Rx_ID = 11'h123;
        build_frame(11'h123, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, -1, -1);
        send_frame(frame_q.size());
        check("d15_dout_n", 64'(dout_n), 64'd1);
        check("d15_pkt",    bus.Rx_packet, 64'h0123_4567_89AB_CDEF);
        check("d15_dlc",    64'(bus.Rx_dlc), 64'd8);

        // Six dominant bits inside the ID
        send_idle(3);
        frame_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        send_frame(frame_q.size());
        check("stf_err_n",  64'(err_n),  64'd1);
        check("stf_err_at", 64'(err_at), 64'd7);
        check("stf_code",   64'(bus.rx_err_code), 64'd0);
        check("stf_ecnt",   64'(bus.Rx_Ecount),   64'd1);
        check("stf_ack_n",  64'(ack_n),  64'd0);

        // Only 5 idle bits after the error: this frame must be ignored
        send_idle(5);
        build_frame(11'h123, 1'b0, 4'd2, PKT_A, -1, -1);
        send_frame(frame_q.size());
        check("ign_dout_n", 64'(dout_n), 64'd0);
        check("ign_ack_n",  64'(ack_n),  64'd0);

        // ACK delimiter + EOF + 3 bits give the 11 idle bits
        send_idle(3);
        send_frame(frame_q.size());
        check("rec_dout_n", 64'(dout_n), 64'd1);
        check("rec_ecnt",   64'(bus.Rx_Ecount), 64'd0);

        // Single CRC bit flipped
        send_idle(3);
        build_frame(11'h123, 1'b0, 4'd2, PKT_A, 0, -1);
        send_frame(frame_q.size());
        check("crc_ack_n",  64'(ack_n),  64'd0);
        check("crc_err_n",  64'(err_n),  64'd1);
        check("crc_err_at", 64'(err_at), 64'(frame_q.size() - 8));
        check("crc_code",   64'(bus.rx_err_code), 64'd1);
        check("crc_ecnt",   64'(bus.Rx_Ecount),   64'd1);

        // Good frame after the CRC error brings the counter back down
        send_idle(4);
        build_frame(11'h123, 1'b0, 4'd2, PKT_A, -1, -1);
        send_frame(frame_q.size());
        check("crc2_dout_n", 64'(dout_n), 64'd1);
        check("crc2_ecnt",   64'(bus.Rx_Ecount),   64'd0);
        check("crc2_code",   64'(bus.rx_err_code), 64'd1);

        // Dominant third EOF bit
        send_idle(3);
        build_frame(11'h123, 1'b0, 4'd2, PKT_A, -1, 2);
        send_frame(frame_q.size());
        check("eof_err_at", 64'(err_at), 64'(frame_q.size() - 5));
        check("eof_code",   64'(bus.rx_err_code), 64'd2);
        check("eof_dout_n", 64'(dout_n), 64'd0);
        check("eof_ecnt",   64'(bus.Rx_Ecount), 64'd1);

        // Asynchronous reset in the middle of the data field
        send_idle(11);
        build_frame(11'h123, 1'b0, 4'd2, PKT_A, -1, -1);
        send_frame(24);
        #2;
        reset = 1'b1;
        #1;
        check_zero("mid_rst");
        @(negedge clock);
        reset = 1'b0;

        send_idle(11);
        send_frame(frame_q.size());
        check("post_dout_n", 64'(dout_n), 64'd1);
        check("post_pkt",    bus.Rx_packet, PKT_A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
